// File: rtl/trgg_adc_scan.sv
// Multi-channel SPI ADC scanner for the trigger input path.
// One shared sequencer clocks NCH ADC links in lockstep (SPI mode 0, MSB first),
// shifts CMD out on mosi and a DW-bit sample in from each miso, then publishes
// all samples at once together with per-channel hysteresis trigger flags.
//
// Output strobe semantics: tval is a single-cycle valid with no ready/backpressure;
// on the cycle tval is high, tout and tflag already hold the new frame and they
// stay stable until the next tval.
module trgg_adc_scan #(
    parameter int              NCH = 2,
    parameter int              DW  = 16,
    parameter int              DIV = 4,
    parameter int              GAP = 8,
    parameter logic [DW-1:0]   CMD = '0,
    parameter logic [DW-1:0]   HYS = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DW-1:0]      thr,
    input  logic [0:NCH-1]     miso,
    output logic [0:NCH-1]     mosi,
    output logic [0:NCH-1]     cs,
    output logic [0:NCH-1]     sclk,
    output logic [0:NCH*DW-1]  tout,
    output logic               tval,
    output logic [0:NCH-1]     tflag
);

    localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_lim;
    logic               w_cnt_done;
    logic [BW-1:0]      r_bit;
    logic               w_last_bit;
    logic               w_lead_go;
    logic               w_rise;
    logic               w_fall;
    logic               w_publish;

    logic               r_cs;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_tval;
    logic [DW-1:0]      r_cmd;
    logic [DW-1:0]      r_thr;
    logic [DW-1:0]      w_thr_lo;
    logic [DW-1:0]      r_shreg [NCH];
    logic [0:NCH*DW-1]  r_tout;
    logic [0:NCH-1]     r_flag;

    assign w_last_bit = (r_bit == BW'(DW - 1));

    // Lower hysteresis bound, saturating at zero so a small threshold never wraps.
    assign w_thr_lo = (r_thr >= HYS) ? (r_thr - HYS) : '0;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus the per-edge control strobes used by the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_lim   = '0;
        w_lead_go   = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            S_LEAD, S_SHIFT: w_cnt_lim = CW'(DIV - 1);
            S_GAP:           w_cnt_lim = CW'(GAP - 1);
            default:         w_cnt_lim = '0;
        endcase
        w_cnt_done = (r_cnt == w_cnt_lim);
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_lead_go   = 1'b1;
                    w_state_nxt = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_cnt_done) begin
                    w_rise      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_cnt_done) begin
                    if (r_sclk) begin
                        w_fall = 1'b1;
                    end else if (w_last_bit) begin
                        w_publish   = 1'b1;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_rise = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_cnt_done) begin
                    if (en) begin
                        w_lead_go   = 1'b1;
                        w_state_nxt = S_LEAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counter: restarts whenever a timed phase (lead, half bit, gap) ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_cnt_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Bit counter: cleared at frame start, advanced on every rising sclk after the first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit <= '0;
        end else if (w_lead_go) begin
            r_bit <= '0;
        end else if (w_rise && r_state == S_SHIFT) begin
            r_bit <= r_bit + BW'(1);
        end
    end

    // SPI line drivers and command shifter; mosi moves only when sclk falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs   <= 1'b1;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_cmd  <= '0;
        end else begin
            if (w_lead_go) begin
                r_cs   <= 1'b0;
                r_sclk <= 1'b0;
                r_mosi <= CMD[DW-1];
                r_cmd  <= {CMD[DW-2:0], 1'b0};
            end
            if (w_rise) begin
                r_sclk <= 1'b1;
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                r_mosi <= r_cmd[DW-1];
                r_cmd  <= {r_cmd[DW-2:0], 1'b0};
            end
            if (w_publish) begin
                r_cs <= 1'b1;
            end
        end
    end

    // Threshold is frozen at frame start so mid-frame changes cannot affect a compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_thr <= '0;
        end else if (w_lead_go) begin
            r_thr <= thr;
        end
    end

    // Per-channel receive shift registers, loaded on each sclk rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_shreg[i] <= '0;
            end
        end else if (w_rise) begin
            for (int i = 0; i < NCH; i++) begin
                r_shreg[i] <= {r_shreg[i][DW-2:0], miso[i]};
            end
        end
    end

    // Publish samples and update hysteresis flags as chip select rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tout <= '0;
            r_flag <= '0;
            r_tval <= 1'b0;
        end else begin
            r_tval <= w_publish;
            if (w_publish) begin
                for (int i = 0; i < NCH; i++) begin
                    r_tout[DW*i +: DW] <= r_shreg[i];
                    if (r_shreg[i] >= r_thr) begin
                        r_flag[i] <= 1'b1;
                    end else if (r_shreg[i] < w_thr_lo) begin
                        r_flag[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign cs    = {NCH{r_cs}};
    assign sclk  = {NCH{r_sclk}};
    assign mosi  = {NCH{r_mosi}};
    assign tout  = r_tout;
    assign tval  = r_tval;
    assign tflag = r_flag;

endmodule
